// File: rtl/bus_cycle_terminator_pkg.sv
// Shared encodings for the 68030 bus cycle terminator: signal polarity,
// DSACK port-size codes, FSM states and cycle source classes.
package bus_cycle_terminator_pkg;

    localparam logic ACTIVE   = 1'b0;
    localparam logic INACTIVE = 1'b1;

    localparam logic [1:0] DSACK_32   = 2'b00;
    localparam logic [1:0] DSACK_16   = 2'b01;
    localparam logic [1:0] DSACK_8    = 2'b10;
    localparam logic [1:0] DSACK_NONE = 2'b11;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2,
        BERR = 2'd3
    } state_e;

    // Who is expected to end the current cycle
    typedef enum logic [1:0] {
        SRC_LOCAL = 2'd0,
        SRC_VME   = 2'd1,
        SRC_NONE  = 2'd2
    } src_e;

endpackage

// File: rtl/bus_cycle_terminator_sync.sv
// Two-flop synchroniser for asynchronous active-low VME strobes.
// Resets to the inactive level so a reset never looks like a strobe.
module async_input_sync (
    input  logic clock,
    input  logic n_reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Shift the raw input through two flops to settle metastability
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/bus_cycle_terminator.sv
// Responder side of the 68030 local bus: terminates every cycle with DSACK
// (port-size encoded) after per-device wait states, forwards VME DTACK/BERR,
// and raises BERR when nothing answers within the timeout window.
module bus_cycle_terminator
    import bus_cycle_terminator_pkg::*;
#(
    parameter int RAM_WAIT    = 1,
    parameter int ROM_WAIT    = 3,
    parameter int SERIAL_WAIT = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic       clock,
    input  logic       n_reset,
    input  logic       cpu_as,
    input  logic       request_ram,
    input  logic       request_rom,
    input  logic       request_serial,
    input  logic       request_vme,
    input  logic       vme_dtack,
    input  logic       vme_berr,
    output logic [1:0] cpu_dsack,
    output logic       cpu_berr
);

    localparam logic [CNT_W-1:0] RAM_CNT = CNT_W'(RAM_WAIT);
    localparam logic [CNT_W-1:0] ROM_CNT = CNT_W'(ROM_WAIT);
    localparam logic [CNT_W-1:0] SER_CNT = CNT_W'(SERIAL_WAIT);
    localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(TIMEOUT);

    state_e           state_q;
    src_e             src_q;
    logic [1:0]       port_q;
    logic [1:0]       dsack_q;
    logic             berr_q;
    logic [CNT_W-1:0] wait_q;
    logic [CNT_W-1:0] tmo_q;
    logic             dtack_s;
    logic             berr_s;

    async_input_sync u_sync_dtack (
        .clock   (clock),
        .n_reset (n_reset),
        .d_i     (vme_dtack),
        .q_o     (dtack_s)
    );

    async_input_sync u_sync_berr (
        .clock   (clock),
        .n_reset (n_reset),
        .d_i     (vme_berr),
        .q_o     (berr_s)
    );

    // Cycle FSM with registered DSACK/BERR; abort beats every termination,
    // VME BERR beats DTACK, and any ACK beats a coincident timeout.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= IDLE;
            src_q   <= SRC_NONE;
            port_q  <= DSACK_NONE;
            dsack_q <= DSACK_NONE;
            berr_q  <= INACTIVE;
            wait_q  <= '0;
            tmo_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cpu_as == ACTIVE) begin
                        state_q <= WAIT;
                        tmo_q   <= '0;
                        wait_q  <= '0;
                        if (request_ram == ACTIVE) begin
                            src_q  <= SRC_LOCAL;
                            port_q <= DSACK_32;
                            wait_q <= RAM_CNT;
                        end else if (request_rom == ACTIVE) begin
                            src_q  <= SRC_LOCAL;
                            port_q <= DSACK_16;
                            wait_q <= ROM_CNT;
                        end else if (request_serial == ACTIVE) begin
                            src_q  <= SRC_LOCAL;
                            port_q <= DSACK_8;
                            wait_q <= SER_CNT;
                        end else if (request_vme == ACTIVE) begin
                            src_q  <= SRC_VME;
                            port_q <= DSACK_32;
                        end else begin
                            src_q  <= SRC_NONE;
                            port_q <= DSACK_NONE;
                        end
                    end
                end
                WAIT: begin
                    // Both counters saturate rather than wrap
                    if (tmo_q != '1) tmo_q <= tmo_q + 1'b1;
                    if (wait_q != '0) wait_q <= wait_q - 1'b1;
                    if (cpu_as == INACTIVE) begin
                        state_q <= IDLE;
                    end else if (src_q == SRC_VME && berr_s == ACTIVE) begin
                        state_q <= BERR;
                        berr_q  <= ACTIVE;
                    end else if ((src_q == SRC_VME && dtack_s == ACTIVE) ||
                                 (src_q == SRC_LOCAL && wait_q == '0)) begin
                        state_q <= ACK;
                        dsack_q <= port_q;
                    end else if (tmo_q == TMO_CNT) begin
                        state_q <= BERR;
                        berr_q  <= ACTIVE;
                    end
                end
                ACK: begin
                    if (cpu_as == INACTIVE) begin
                        state_q <= IDLE;
                        dsack_q <= DSACK_NONE;
                    end
                end
                BERR: begin
                    if (cpu_as == INACTIVE) begin
                        state_q <= IDLE;
                        berr_q  <= INACTIVE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cpu_dsack = dsack_q;
    assign cpu_berr  = berr_q;

endmodule

// File: tb/tb_bus_cycle_terminator.sv
// Scoreboard bench: each transaction predicts its output change events
// (edge number, {dsack,berr}) from the timing rules; a negedge monitor pops
// and compares whenever the DUT outputs change.
module tb_bus_cycle_terminator;

    logic       clock = 1'b0;
    logic       n_reset = 1'b0;
    logic       cpu_as = 1'b1;
    logic       request_ram = 1'b1;
    logic       request_rom = 1'b1;
    logic       request_serial = 1'b1;
    logic       request_vme = 1'b1;
    logic       vme_dtack = 1'b1;
    logic       vme_berr = 1'b1;
    logic [1:0] cpu_dsack;
    logic       cpu_berr;

    typedef struct {
        int         cyc;
        logic [2:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   passed = 0;
    int   cyc = 0;
    logic [2:0] prev = 3'b111;

    bus_cycle_terminator dut (
        .clock          (clock),
        .n_reset        (n_reset),
        .cpu_as         (cpu_as),
        .request_ram    (request_ram),
        .request_rom    (request_rom),
        .request_serial (request_serial),
        .request_vme    (request_vme),
        .vme_dtack      (vme_dtack),
        .vme_berr       (vme_berr),
        .cpu_dsack      (cpu_dsack),
        .cpu_berr       (cpu_berr)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: every output change must match the next predicted event
    always @(negedge clock) begin
        logic [2:0] cur;
        exp_t e;
        cur = {cpu_dsack, cpu_berr};
        if (cur !== prev) begin
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_change: got %b at edge %0d, none expected", cur, cyc);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc == cyc && e.val === cur) passed++;
                else $display("FAIL event: got %b at edge %0d, want %b at edge %0d",
                              cur, cyc, e.val, e.cyc);
            end
        end
        prev = cur;
    end

    task automatic chk(input string nm, input logic [2:0] act, input logic [2:0] want);
        total++;
        if (act === want) passed++;
        else $display("FAIL %s: got %b want %b", nm, act, want);
    endtask

    task automatic push(input int c, input logic [2:0] v);
        exp_t e;
        e.cyc = c;
        e.val = v;
        exp_q.push_back(e);
    endtask

    // dev: 0 RAM, 1 ROM, 2 serial, 3 VME, 4 no request
    // d: VME strobe driven just after edge t0+d; vmode 0 dtack, 1 berr, 2 both
    // abort_at: cpu_as sampled high at edge t0+abort_at (0 = never)
    task automatic run_txn(input int dev, input int d, input int vmode,
                           input int hold, input int abort_at, input int gap);
        int         wt[3];
        logic [1:0] pc[3];
        int         t0, a, ae, end_edge;
        logic [2:0] term;
        bit         aborted;
        wt = '{1, 3, 4};
        pc = '{2'b00, 2'b01, 2'b10};
        t0 = cyc + 1;
        cpu_as = 1'b0;
        request_ram    = (dev == 0) ? 1'b0 : 1'b1;
        request_rom    = (dev == 1) ? 1'b0 : 1'b1;
        request_serial = (dev == 2) ? 1'b0 : 1'b1;
        request_vme    = (dev == 3) ? 1'b0 : 1'b1;
        if (dev < 3) begin
            a = t0 + wt[dev] + 1;
            term = {pc[dev], 1'b1};
        end else if (dev == 3) begin
            a = t0 + d + 3;
            term = (vmode == 0) ? 3'b001 : 3'b110;
            if (a > t0 + 256) begin
                a = t0 + 256;
                term = 3'b110;
            end
        end else begin
            a = t0 + 256;
            term = 3'b110;
        end
        ae = t0 + abort_at;
        aborted = (abort_at > 0) && (ae <= a);
        if (aborted) begin
            end_edge = ae;
        end else begin
            end_edge = a + hold + 1;
            push(a, term);
            push(end_edge, 3'b111);
        end
        while (cyc < end_edge) begin
            @(posedge clock); #1;
            if (dev == 3 && cyc == t0 + d) begin
                if (vmode != 1) vme_dtack = 1'b0;
                if (vmode != 0) vme_berr = 1'b0;
            end
            if (cyc == end_edge - 1) cpu_as = 1'b1;
        end
        request_ram = 1'b1;
        request_rom = 1'b1;
        request_serial = 1'b1;
        request_vme = 1'b1;
        vme_dtack = 1'b1;
        vme_berr = 1'b1;
        repeat (gap) begin
            @(posedge clock); #1;
        end
    endtask

    // RAM cycle hit by reset while DSACK is asserted
    task automatic reset_mid_cycle();
        int t0, a;
        t0 = cyc + 1;
        cpu_as = 1'b0;
        request_ram = 1'b0;
        a = t0 + 2;
        push(a, 3'b001);
        push(a + 1, 3'b111);
        while (cyc < a + 1) begin
            @(posedge clock); #1;
        end
        n_reset = 1'b0;
        #1;
        chk("rst_mid_dsack", {1'b0, cpu_dsack}, 3'b011);
        chk("rst_mid_berr", {2'b00, cpu_berr}, 3'b001);
        cpu_as = 1'b1;
        request_ram = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        n_reset = 1'b1;
        repeat (3) begin
            @(posedge clock); #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r, dev, ab;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_dsack", {1'b0, cpu_dsack}, 3'b011);
        chk("reset_berr", {2'b00, cpu_berr}, 3'b001);
        n_reset = 1'b1;
        repeat (3) begin
            @(posedge clock); #1;
        end
        run_txn(0, 0, 0, 1, 0, 3);      // RAM read
        run_txn(1, 0, 0, 0, 0, 3);      // ROM ...
        run_txn(2, 0, 0, 2, 0, 3);      // ... then serial
        run_txn(3, 9, 0, 2, 0, 3);      // VME dtack
        run_txn(3, 5, 1, 1, 0, 3);      // VME berr
        run_txn(3, 4, 2, 0, 0, 3);      // dtack+berr together: berr wins
        run_txn(4, 0, 0, 2, 0, 3);      // no request: timeout
        run_txn(1, 0, 0, 0, 2, 3);      // aborted ROM
        run_txn(0, 0, 0, 0, 0, 3);      // RAM after abort
        run_txn(3, 253, 0, 1, 0, 3);    // dtack on the timeout edge: ACK wins
        run_txn(3, 254, 0, 1, 0, 3);    // dtack one edge late: timeout
        reset_mid_cycle();
        run_txn(0, 0, 0, 0, 0, 3);      // normal after reset
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            dev = (r < 3) ? r : ((r < 9) ? 3 : 4);
            ab = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 6) : 0;
            run_txn(dev, $urandom_range(0, 20), $urandom_range(0, 2),
                    $urandom_range(0, 3), ab, $urandom_range(3, 5));
        end
        repeat (5) begin
            @(posedge clock); #1;
        end
        total++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL pending_events: got %0d unseen, want 0", exp_q.size());
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
